shift_unit: RTL and testbench
=============================

SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, as listed below.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 flush  input  1  synchronous pipeline clear.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  unit accepts the beat this cycle.
REQ-007 op  input  2  operation select: 00 MOV (pass value), 01 LSL, 10 ASR, 11 ROR.
REQ-008 value  input  32  operand to shift.
REQ-009 shcnt  input  32  shift count; only bits [4:0] are used.
REQ-010 dst  input  4  destination register tag.
REQ-011 out_valid  output  1  result beat offered.
REQ-012 out_ready  input  1  consumer accepts the result beat.
REQ-013 res  output  32  shift result.
REQ-014 out_dst  output  4  tag travelling with res.
REQ-015 res_n, res_z  output  1 each  sign and zero flags of res; present only per REQ-031.

Function
REQ-016 Structure: two register stages. S1 holds op, value, shcnt[4:0], dst and s1_valid. S2 holds res, dst and s2_valid.
REQ-017 The logical-left, arithmetic-right and rotate-right shifters SHALL be instantiated between S1 and S2; no shifting logic duplicated locally.
REQ-018 Shift amounts are taken modulo 32; shcnt 32 behaves as 0, shcnt 33 behaves as 1.
REQ-019 MOV SHALL ignore shcnt.
REQ-020 Handshake: a beat transfers when valid and ready are both high at a rising edge.
REQ-021 s1_adv = s1_valid & (~s2_valid | out_ready).
REQ-022 in_ready = ~s1_valid | s1_adv, combinational.
REQ-023 out_valid = s2_valid; res and out_dst are S2 contents.
REQ-024 Latency: result is visible 2 cycles after acceptance when out_ready is held high.
REQ-025 Throughput: one beat per cycle when out_ready is held high.
REQ-026 Backpressure: while out_valid=1 and out_ready=0, S2 holds. S1 fills at most one more beat, then in_ready=0. No beat is lost or duplicated.
REQ-027 Simultaneous accept and retire: S1 reloads in the same cycle it advances. S2 loads the new result in the same cycle it is drained.
REQ-028 Output stability: res and out_dst SHALL NOT change while out_valid=1 and out_ready=0.
REQ-029 flush=1 clears s1_valid and s2_valid at the next edge and overrides any accept in that cycle. Data registers may retain stale values.

Reset
REQ-030 While rst_n=0, independent of clk: s1_valid=0, s2_valid=0, in_ready=1, out_valid=0, res=0, out_dst=0, res_n=0, res_z=0. Reset asserted mid-operation discards all in-flight beats.

Configuration
REQ-031 Macro SHIFT_FLAGS_EN.
- Defined: res_n and res_z ports exist. Both are registered in S2 with res: res_n=res[31], res_z=(res==0).
- Undefined: both ports and their registers are absent; all other behaviour is identical.

Verification
REQ-032 LSL value=0x0000_0001, shcnt=31, out_ready=1 -> res=0x8000_0000 two cycles later. With SHIFT_FLAGS_EN: res_n=1, res_z=0.
REQ-033 ASR value=0x8000_0000, shcnt=4 -> res=0xF800_0000. ROR value=0x0000_00F1, shcnt=36 -> res=0x1000_000F.
REQ-034 Back-to-back beats, tags 1..8, out_ready=1 -> eight consecutive out_valid cycles, tags in order, no bubbles.
REQ-035 out_ready=0 for 5 cycles while 3 beats are offered -> in_ready drops after 2 accepts, res holds steady. On release, both beats emerge in order and the third is accepted.
REQ-036 Flush: flush=1 with both stages full -> out_valid=0 next cycle.
REQ-037 rst_n pulsed low between clock edges -> out_valid=0 and res=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/shift_unit.sv
// Two-stage MOV/LSL/ASR/ROR unit with valid/ready flow control.
// Optional sign/zero result flags under SHIFT_FLAGS_EN.
module shl32 (
  input  logic [31:0] a,
  input  logic [4:0]  amt,
  output logic [31:0] y
);
  assign y = a << amt;
endmodule

module asr32 (
  input  logic [31:0] a,
  input  logic [4:0]  amt,
  output logic [31:0] y
);
  assign y = $unsigned($signed(a) >>> amt);
endmodule

module ror32 (
  input  logic [31:0] a,
  input  logic [4:0]  amt,
  output logic [31:0] y
);
  logic [63:0] dbl;
  assign dbl = {a, a} >> amt;
  assign y   = dbl[31:0];
endmodule

module shift_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] value,
  input  logic [31:0] shcnt,
  input  logic [3:0]  dst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic [3:0]  out_dst
`ifdef SHIFT_FLAGS_EN
  ,
  output logic        res_n,
  output logic        res_z
`endif
);

  typedef enum logic [1:0] {
    OP_MOV = 2'b00,
    OP_LSL = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  op_e         s1_op;
  logic [31:0] s1_value;
  logic [4:0]  s1_cnt;
  logic [3:0]  s1_dst;
  logic        s1_valid;
  logic        s2_valid;

  logic        s1_adv;
  logic        accept;
  logic [31:0] lsl_y;
  logic [31:0] asr_y;
  logic [31:0] ror_y;
  logic [31:0] res_d;
  logic        unused_shcnt;

  // only the low five bits select the amount: counts wrap modulo 32
  assign unused_shcnt = ^shcnt[31:5];

  assign s1_adv    = s1_valid & (~s2_valid | out_ready);
  assign in_ready  = ~s1_valid | s1_adv;
  assign accept    = in_valid & in_ready;
  assign out_valid = s2_valid;

  shl32 u_lsl (.a(s1_value), .amt(s1_cnt), .y(lsl_y));
  asr32 u_asr (.a(s1_value), .amt(s1_cnt), .y(asr_y));
  ror32 u_ror (.a(s1_value), .amt(s1_cnt), .y(ror_y));

  always_comb begin
    res_d = s1_value;
    unique case (s1_op)
      OP_MOV: res_d = s1_value;
      OP_LSL: res_d = lsl_y;
      OP_ASR: res_d = asr_y;
      OP_ROR: res_d = ror_y;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_MOV;
      s1_value <= '0;
      s1_cnt   <= '0;
      s1_dst   <= '0;
    end else begin
      if (flush)
        s1_valid <= 1'b0;
      else if (accept)
        s1_valid <= 1'b1;
      else if (s1_adv)
        s1_valid <= 1'b0;
      if (accept && !flush) begin
        s1_op    <= op_e'(op);
        s1_value <= value;
        s1_cnt   <= shcnt[4:0];
        s1_dst   <= dst;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      res      <= '0;
      out_dst  <= '0;
`ifdef SHIFT_FLAGS_EN
      res_n    <= 1'b0;
      res_z    <= 1'b0;
`endif
    end else begin
      if (flush)
        s2_valid <= 1'b0;
      else if (s1_adv)
        s2_valid <= 1'b1;
      else if (out_ready)
        s2_valid <= 1'b0;
      if (s1_adv && !flush) begin
        res     <= res_d;
        out_dst <= s1_dst;
`ifdef SHIFT_FLAGS_EN
        res_n   <= res_d[31];
        res_z   <= (res_d == 32'd0);
`endif
      end
    end
  end

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit: shifts, streaming, backpressure,
// flush and asynchronous reset.
module tb_shift_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] value;
  logic [31:0] shcnt;
  logic [3:0]  dst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic [3:0]  out_dst;
`ifdef SHIFT_FLAGS_EN
  logic        res_n;
  logic        res_z;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  shift_unit dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .value(value), .shcnt(shcnt), .dst(dst),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .out_dst(out_dst)
`ifdef SHIFT_FLAGS_EN
    , .res_n(res_n), .res_z(res_z)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] o, input logic [31:0] v,
                       input logic [31:0] c, input logic [3:0] t);
    in_valid = 1'b1;
    op       = o;
    value    = v;
    shcnt    = c;
    dst      = t;
  endtask

  // one beat on an idle pipeline, result checked exactly 2 edges later
  task automatic one_beat(input string tag, input logic [1:0] o,
                          input logic [31:0] v, input logic [31:0] c,
                          input logic [3:0] t, input logic [31:0] exp);
    out_ready = 1'b1;
    drive(o, v, c, t);
    tick();
    in_valid = 1'b0;
    tick();
    check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_res"}, res, exp);
    check({tag, "_dst"}, {28'd0, out_dst}, {28'd0, t});
`ifdef SHIFT_FLAGS_EN
    check({tag, "_n"}, {31'd0, res_n}, {31'd0, exp[31]});
    check({tag, "_z"}, {31'd0, res_z}, {31'd0, exp == 32'd0});
`endif
    tick();
    check({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 2'b00; value = '0; shcnt = '0; dst = '0;
    #12;
    check("rst_vld", {31'd0, out_valid}, 32'd0);
    check("rst_rdy", {31'd0, in_ready}, 32'd1);
    check("rst_res", res, 32'd0);
    check("rst_dst", {28'd0, out_dst}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    one_beat("lsl31", 2'b01, 32'h0000_0001, 32'd31, 4'd3, 32'h8000_0000);
    one_beat("asr4", 2'b10, 32'h8000_0000, 32'd4, 4'd4, 32'hF800_0000);
    one_beat("ror36", 2'b11, 32'h0000_00F1, 32'd36, 4'd5, 32'h1000_000F);
    one_beat("mov", 2'b00, 32'h1234_5678, 32'd5, 4'd6, 32'h1234_5678);
    one_beat("lsl32", 2'b01, 32'h0000_00A5, 32'd32, 4'd7, 32'h0000_00A5);
    one_beat("lsl33", 2'b01, 32'h0000_0003, 32'd33, 4'd8, 32'h0000_0006);
    one_beat("asrpos", 2'b10, 32'h7000_0000, 32'd4, 4'd9, 32'h0700_0000);
    one_beat("asr31", 2'b10, 32'hFFFF_FFFF, 32'd31, 4'd10, 32'hFFFF_FFFF);
    one_beat("ror0", 2'b11, 32'h8000_0001, 32'd0, 4'd11, 32'h8000_0001);
    one_beat("ror1", 2'b11, 32'h0000_0001, 32'd1, 4'd12, 32'h8000_0000);
    one_beat("zero", 2'b01, 32'h8000_0000, 32'd1, 4'd13, 32'h0000_0000);

    // back-to-back stream of tags 1..8
    out_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      if (j < 8)
        drive(2'b00, 32'h1111 * (j + 1), 32'd0, 4'(j + 1));
      else
        in_valid = 1'b0;
      if (j >= 2) begin
        check("b2b_vld", {31'd0, out_valid}, 32'd1);
        check("b2b_dst", {28'd0, out_dst}, 32'(j - 1));
        check("b2b_res", res, 32'h1111 * (j - 1));
      end
      if (j < 8)
        check("b2b_rdy", {31'd0, in_ready}, 32'd1);
      tick();
    end
    check("b2b_end", {31'd0, out_valid}, 32'd0);

    // backpressure: 5 stalled cycles, three beats offered
    out_ready = 1'b0;
    drive(2'b00, 32'h0000_00AA, 32'd0, 4'd9);
    tick();
    check("bp_rdy1", {31'd0, in_ready}, 32'd1);
    drive(2'b00, 32'h0000_00BB, 32'd0, 4'd10);
    tick();
    drive(2'b00, 32'h0000_00CC, 32'd0, 4'd11);
    check("bp_rdy2", {31'd0, in_ready}, 32'd0);
    check("bp_vld", {31'd0, out_valid}, 32'd1);
    check("bp_dst", {28'd0, out_dst}, 32'd9);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
      check("bp_hold_res", res, 32'h0000_00AA);
      check("bp_hold_dst", {28'd0, out_dst}, 32'd9);
    end
    out_ready = 1'b1;
    #1;
    check("bp_rel_rdy", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_b_dst", {28'd0, out_dst}, 32'd10);
    check("bp_b_res", res, 32'h0000_00BB);
    tick();
    check("bp_c_vld", {31'd0, out_valid}, 32'd1);
    check("bp_c_dst", {28'd0, out_dst}, 32'd11);
    check("bp_c_res", res, 32'h0000_00CC);
    tick();
    check("bp_end", {31'd0, out_valid}, 32'd0);

    // flush with both stages full
    out_ready = 1'b0;
    drive(2'b01, 32'h1, 32'd1, 4'd1);
    tick();
    drive(2'b01, 32'h1, 32'd2, 4'd2);
    tick();
    in_valid = 1'b0;
    check("fl_full", {31'd0, out_valid}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_vld", {31'd0, out_valid}, 32'd0);
    check("fl_rdy", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick();
    check("fl_s1gone", {31'd0, out_valid}, 32'd0);

    // flush overrides a same-cycle accept
    drive(2'b00, 32'h55, 32'd0, 4'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
    check("fl_acc", {31'd0, out_valid}, 32'd0);

    // asynchronous reset mid-cycle
    drive(2'b00, 32'hDEAD_BEEF, 32'd0, 4'd14);
    tick();
    in_valid = 1'b0;
    tick();
    check("ar_pre", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_vld", {31'd0, out_valid}, 32'd0);
    check("ar_res", res, 32'd0);
    check("ar_dst", {28'd0, out_dst}, 32'd0);
    check("ar_rdy", {31'd0, in_ready}, 32'd1);
`ifdef SHIFT_FLAGS_EN
    check("ar_n", {31'd0, res_n}, 32'd0);
    check("ar_z", {31'd0, res_z}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("ar_after", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
